// File: rtl/regfile_pkg.sv
// Shared sizing defaults and word/address types for the integer register file.
package regfile_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int NUM_REGS       = 2**ADDR_W_DEFAULT;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0]   xlen_word_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0 forced to zero, optional write-through.
// Write-through compare is present only when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int XLEN   = XLEN_DEFAULT
) (
  input  logic [2**ADDR_W-1:1][XLEN-1:0] mem,
  input  logic [ADDR_W-1:0]              ra,
`ifdef REGFILE_WRITE_BYPASS_EN
  input  logic                           reset_n,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              wa,
  input  logic [XLEN-1:0]                wd,
`endif
  output logic [XLEN-1:0]                rd
);

  always_comb begin
    rd = '0;
    if (ra != '0) begin
      rd = mem[ra];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    // wa != 0 together with ra == wa already keeps x0 at zero
    if (reset_n && we && (wa != '0) && (ra == wa)) begin
      rd = wd;
    end
`endif
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write RV32I register file; x0 reads zero, writes commit on rising clk.
// Optional write-through reads via REGFILE_WRITE_BYPASS_EN; reset clears all entries asynchronously.
module register_file
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int XLEN   = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [XLEN-1:0]   wd3,
  output logic [XLEN-1:0]   rd1,
  output logic [XLEN-1:0]   rd2
);

  localparam int DEPTH = 2**ADDR_W;

  // Entry 0 has no storage; the array starts at index 1.
  logic [DEPTH-1:1][XLEN-1:0] mem_q;
  logic [DEPTH-1:1][XLEN-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we3 && (wa3 != '0)) begin
      mem_d[wa3] = wd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_read_port #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_port1 (
    .mem     (mem_q),
    .ra      (ra1),
`ifdef REGFILE_WRITE_BYPASS_EN
    .reset_n (reset_n),
    .we      (we3),
    .wa      (wa3),
    .wd      (wd3),
`endif
    .rd      (rd1)
  );

  regfile_read_port #(
    .ADDR_W (ADDR_W),
    .XLEN   (XLEN)
  ) u_port2 (
    .mem     (mem_q),
    .ra      (ra2),
`ifdef REGFILE_WRITE_BYPASS_EN
    .reset_n (reset_n),
    .we      (we3),
    .wa      (wa3),
    .wd      (wd3),
`endif
    .rd      (rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file; expectations follow REGFILE_WRITE_BYPASS_EN when defined.
module tb_register_file;

  logic        clk;
  logic        reset_n;
  logic        we3;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks;
  int errors;

  register_file #(.ADDR_W(5), .XLEN(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .we3     (we3),
    .ra1     (ra1),
    .ra2     (ra2),
    .wa3     (wa3),
    .wd3     (wd3),
    .rd1     (rd1),
    .rd2     (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    we3 = 1'b0; wa3 = 5'd0; wd3 = 32'h0;
    ra1 = 5'd31; ra2 = 5'd1;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1 got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2 got %h want %h", rd2, 32'h0); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write_sweep();
    logic [31:0] exp1, exp2;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      we3 = 1'b1; wa3 = 5'(a); wd3 = 32'(a * 2);
    end
    @(negedge clk);
    we3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'((i << 2) % 32);
      #1;
      exp1 = (i == 0) ? 32'h0 : 32'(i * 2);
      exp2 = (((i << 2) % 32) == 0) ? 32'h0 : 32'(((i << 2) % 32) * 2);
      checks++;
      if (rd1 !== exp1) begin errors++; $display("FAIL sweep_rd1[%0d] got %h want %h", i, rd1, exp1); end
      checks++;
      if (rd2 !== exp2) begin errors++; $display("FAIL sweep_rd2[%0d] got %h want %h", i, rd2, exp2); end
    end
  endtask

  task automatic test_we_off();
    @(negedge clk);
    we3 = 1'b0; wa3 = 5'd5; wd3 = 32'hDEADBEEF; ra1 = 5'd5;
    @(negedge clk);
    #1;
    checks++;
    if (rd1 !== 32'hA) begin errors++; $display("FAIL we_off_rd1 got %h want %h", rd1, 32'hA); end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_pre_rd1 got %h want %h", rd1, 32'h0); end
    @(negedge clk);
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL x0_rd1 got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin errors++; $display("FAIL x0_rd2 got %h want %h", rd2, 32'h0); end
  endtask

  task automatic test_dual_port();
    @(negedge clk);
    ra1 = 5'd17; ra2 = 5'd17;
    #1;
    checks++;
    if (rd1 !== 32'h22) begin errors++; $display("FAIL dual_rd1 got %h want %h", rd1, 32'h22); end
    checks++;
    if (rd2 !== 32'h22) begin errors++; $display("FAIL dual_rd2 got %h want %h", rd2, 32'h22); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pre;
`ifdef REGFILE_WRITE_BYPASS_EN
    exp_pre = 32'h1234;
`else
    exp_pre = 32'h12;
`endif
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd9; wd3 = 32'h1234; ra1 = 5'd9; ra2 = 5'd8;
    #1;
    checks++;
    if (rd1 !== exp_pre) begin errors++; $display("FAIL same_pre_rd1 got %h want %h", rd1, exp_pre); end
    checks++;
    if (rd2 !== 32'h10) begin errors++; $display("FAIL same_pre_rd2 got %h want %h", rd2, 32'h10); end
    @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 32'h1234) begin errors++; $display("FAIL same_post_rd1 got %h want %h", rd1, 32'h1234); end
    @(negedge clk);
    we3 = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h1234) begin errors++; $display("FAIL same_hold_rd1 got %h want %h", rd1, 32'h1234); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    ra1 = 5'd31; ra2 = 5'd30;
    #1;
    checks++;
    if (rd1 !== 32'h3E) begin errors++; $display("FAIL prereset_rd1 got %h want %h", rd1, 32'h3E); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL async_rd1 got %h want %h", rd1, 32'h0); end
    checks++;
    if (rd2 !== 32'h0) begin errors++; $display("FAIL async_rd2 got %h want %h", rd2, 32'h0); end
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h55; ra1 = 5'd7;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_wr_pre_rd1 got %h want %h", rd1, 32'h0); end
    @(negedge clk);
    we3 = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_drop_rd1 got %h want %h", rd1, 32'h0); end
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h55;
    @(posedge clk);
    #1;
    checks++;
    if (rd1 !== 32'h55) begin errors++; $display("FAIL post_rst_wr_rd1 got %h want %h", rd1, 32'h55); end
    @(negedge clk);
    we3 = 1'b0;
    ra2 = 5'd9;
    #1;
    checks++;
    if (rd2 !== 32'h0) begin errors++; $display("FAIL post_rst_rd2 got %h want %h", rd2, 32'h0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write_sweep();
    test_we_off();
    test_x0();
    test_dual_port();
    test_same_cycle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
